// File: rtl/conv_mac_unit_if.sv
// conv_mac_unit_if
// Bundles the kernel-buffer handshake, the window stream and the result
// stream of conv_mac_unit into one interface.
//   kernel_valid_i  per-channel "kernel loaded" flags from the kernel buffer
//   kernel_i        TAPS kernel words, channel-major then row-major
//   bias_i          bias of the current kernel
//   hold_kernel_o   per-channel hold; drops for one cycle to release kernels
//   window_valid_i  window_i carries a valid window
//   window_i        TAPS window words, same ordering as kernel_i
//   window_ready_o  window taken this cycle
//   result_o        output pixel
//   result_valid_o  result_o is valid
//   result_ready_i  downstream takes result_o this cycle
// The slave modport is the MAC unit; the master modport is its environment.

interface conv_mac_unit_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int N_CHANNELS  = 1,
   parameter int KERNEL_SIZE = 3
);
   localparam int TAPS = N_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;

   logic [N_CHANNELS-1:0]             kernel_valid_i;
   logic [TAPS-1:0][DATA_WIDTH-1:0]   kernel_i;
   logic [DATA_WIDTH-1:0]             bias_i;
   logic [N_CHANNELS-1:0]             hold_kernel_o;
   logic                              window_valid_i;
   logic [TAPS-1:0][DATA_WIDTH-1:0]   window_i;
   logic                              window_ready_o;
   logic [DATA_WIDTH-1:0]             result_o;
   logic                              result_valid_o;
   logic                              result_ready_i;

   modport master (
      output kernel_valid_i, kernel_i, bias_i, window_valid_i, window_i, result_ready_i,
      input  hold_kernel_o, window_ready_o, result_o, result_valid_o
   );

   modport slave (
      input  kernel_valid_i, kernel_i, bias_i, window_valid_i, window_i, result_ready_i,
      output hold_kernel_o, window_ready_o, result_o, result_valid_o
   );
endinterface

// File: rtl/conv_mac_unit.sv
// conv_mac_unit
// Sequential multiply-accumulate engine for one convolution output pixel.
// A window is accepted when every kernel channel is loaded, then one tap is
// multiplied and accumulated per cycle, the sum is rescaled, biased,
// saturated and optionally ReLU-clamped, and the pixel is offered on a
// valid/ready output. After N_WINDOWS pixels the kernel is released for one
// cycle so the kernel buffer can load the next one.
//   clock_i   sole clock, rising edge
//   reset_ni  asynchronous active-low reset
//   enable_i  0 freezes all state
//   bus       conv_mac_unit_if slave: kernel, window and result handshakes

module conv_mac_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int N_CHANNELS  = 1,
   parameter int KERNEL_SIZE = 3,
   parameter int FRAC_BITS   = 16,
   parameter int N_WINDOWS   = 676,
   parameter int RELU_EN     = 1
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             enable_i,
   conv_mac_unit_if.slave   bus
);
   localparam int TAPS  = N_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
   localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int ACC_W = 2 * DATA_WIDTH + $clog2(TAPS);
   localparam int SUM_W = ACC_W + 1;
   localparam int CNT_W = (N_WINDOWS > 1) ? $clog2(N_WINDOWS) : 1;

   typedef enum logic [2:0] {IDLE, MAC, BIAS, OUTPUT, RELEASE} state_t;

   state_t                          state_q, state_d;
   logic [TAPS-1:0][DATA_WIDTH-1:0] win_q, win_d;
   logic signed [ACC_W-1:0]         acc_q, acc_d;
   logic [TAP_W-1:0]                tap_q, tap_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]           result_q, result_d;

   logic signed [2*DATA_WIDTH-1:0]  win_ext, ker_ext, product;
   logic signed [SUM_W-1:0]         biased;
   logic [SUM_W-DATA_WIDTH:0]       headroom;
   logic [DATA_WIDTH-1:0]           saturated, activated;
   logic                            accept;

   // Datapath for the current tap and for the final rescale. Operands are
   // sign-extended to full product width so the multiply keeps all 2*DW bits.
   // The result fits the output word only if every bit from the output sign
   // bit upward is identical; otherwise it clamps toward the sign of the sum.
   always_comb begin
      win_ext  = $signed({{DATA_WIDTH{win_q[tap_q][DATA_WIDTH-1]}}, win_q[tap_q]});
      ker_ext  = $signed({{DATA_WIDTH{bus.kernel_i[tap_q][DATA_WIDTH-1]}}, bus.kernel_i[tap_q]});
      product  = win_ext * ker_ext;
      biased   = SUM_W'(acc_q >>> FRAC_BITS) + SUM_W'($signed(bus.bias_i));
      headroom = biased[SUM_W-1:DATA_WIDTH-1];
      if ((&headroom) || (~|headroom)) begin
         saturated = biased[DATA_WIDTH-1:0];
      end else if (biased[SUM_W-1]) begin
         saturated = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         saturated = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      activated = ((RELU_EN != 0) && saturated[DATA_WIDTH-1]) ? '0 : saturated;
   end

   assign accept = enable_i && (state_q == IDLE) && (&bus.kernel_valid_i) && bus.window_valid_i;

   // Next-state logic. kernel_valid_i only matters in IDLE; once a window is
   // taken the computation runs to completion regardless of the kernel flags.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      acc_d    = acc_q;
      tap_d    = tap_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (enable_i) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  win_d   = bus.window_i;
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = MAC;
               end
            end
            MAC: begin
               acc_d = acc_q + ACC_W'(product);
               if (tap_q == TAP_W'(TAPS - 1)) begin
                  state_d = BIAS;
               end else begin
                  tap_d = tap_q + TAP_W'(1);
               end
            end
            BIAS: begin
               result_d = activated;
               state_d  = OUTPUT;
            end
            OUTPUT: begin
               if (bus.result_ready_i) begin
                  if (cnt_q == CNT_W'(N_WINDOWS - 1)) begin
                     cnt_d   = '0;
                     state_d = RELEASE;
                  end else begin
                     cnt_d   = cnt_q + CNT_W'(1);
                     state_d = IDLE;
                  end
               end
            end
            RELEASE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State registers; reset abandons any partial computation.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         win_q    <= '0;
         acc_q    <= '0;
         tap_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         acc_q    <= acc_d;
         tap_q    <= tap_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.window_ready_o = accept;
   assign bus.result_valid_o = (state_q == OUTPUT);
   assign bus.result_o       = result_q;
   assign bus.hold_kernel_o  = {N_CHANNELS{state_q != RELEASE}};
endmodule

// File: tb/tb_conv_mac_unit.sv
// tb_conv_mac_unit
// Drives two conv_mac_unit instances (ReLU on and off) with identical
// stimulus and compares both against a behavioural pixel/protocol model.

module tb_conv_mac_unit;
   localparam int DW   = 32;
   localparam int NC   = 1;
   localparam int KS   = 3;
   localparam int FB   = 16;
   localparam int NW   = 3;
   localparam int TAPS = NC * KS * KS;

   logic clock;
   logic reset_n;
   logic enable;
   bit   randEn;

   int checksTotal;
   int checksPassed;

   conv_mac_unit_if #(.DATA_WIDTH(DW), .N_CHANNELS(NC), .KERNEL_SIZE(KS)) busRelu ();
   conv_mac_unit_if #(.DATA_WIDTH(DW), .N_CHANNELS(NC), .KERNEL_SIZE(KS)) busLin ();

   // The linear instance sees exactly the inputs of the ReLU instance.
   assign busLin.kernel_valid_i = busRelu.kernel_valid_i;
   assign busLin.kernel_i       = busRelu.kernel_i;
   assign busLin.bias_i         = busRelu.bias_i;
   assign busLin.window_valid_i = busRelu.window_valid_i;
   assign busLin.window_i       = busRelu.window_i;
   assign busLin.result_ready_i = busRelu.result_ready_i;

   conv_mac_unit #(.DATA_WIDTH(DW), .N_CHANNELS(NC), .KERNEL_SIZE(KS), .FRAC_BITS(FB),
                   .N_WINDOWS(NW), .RELU_EN(1)) dutRelu (
      .clock_i (clock),
      .reset_ni(reset_n),
      .enable_i(enable),
      .bus     (busRelu)
   );

   conv_mac_unit #(.DATA_WIDTH(DW), .N_CHANNELS(NC), .KERNEL_SIZE(KS), .FRAC_BITS(FB),
                   .N_WINDOWS(NW), .RELU_EN(0)) dutLin (
      .clock_i (clock),
      .reset_ni(reset_n),
      .enable_i(enable),
      .bus     (busLin)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Every comparison goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      checksTotal++;
      $display("[TB] FAIL %s: timed out waiting on DUT", name);
   endtask

   // Reference pixel straight from the arithmetic definition: exact dot
   // product, floor-divide by 2^FB, add bias, clamp to 32-bit signed, ReLU.
   function automatic logic [31:0] refPixel(input bit relu);
      logic signed [127:0] acc, a, b;
      logic [31:0] r;
      acc = '0;
      for (int i = 0; i < TAPS; i++) begin
         a   = $signed(busRelu.kernel_i[i]);
         b   = $signed(busRelu.window_i[i]);
         acc = acc + a * b;
      end
      acc = acc >>> FB;
      a   = $signed(busRelu.bias_i);
      acc = acc + a;
      if (acc > 128'sh7FFF_FFFF) r = 32'h7FFF_FFFF;
      else if (acc < -128'sh8000_0000) r = 32'h8000_0000;
      else r = acc[31:0];
      if (relu && r[31]) r = '0;
      return r;
   endfunction

   // Protocol model: a window taken in cycle 0 yields a result in cycle
   // TAPS+2, held until a ready cycle; every NW-th transfer is followed by a
   // one-cycle kernel release.
   bit          mBusy, mOut, mRel;
   int          mLeft, mCount;
   logic [31:0] mExpRelu, mExpLin;

   always @(negedge clock) begin : compareProc
      bit idleNow;
      bit expReady;
      if (!reset_n) begin
         checkOutput("reset hold relu", 32'(busRelu.hold_kernel_o), 32'(1));
         checkOutput("reset valid relu", 32'(busRelu.result_valid_o), 32'(0));
         checkOutput("reset ready relu", 32'(busRelu.window_ready_o), 32'(0));
         checkOutput("reset result lin", busLin.result_o, 32'(0));
         mBusy = 0; mOut = 0; mRel = 0; mLeft = 0; mCount = 0;
      end else begin
         idleNow  = !mBusy && !mOut && !mRel;
         expReady = idleNow && enable && (&busRelu.kernel_valid_i) && busRelu.window_valid_i;
         checkOutput("hold relu", 32'(busRelu.hold_kernel_o), mRel ? 32'(0) : 32'(1));
         checkOutput("hold lin", 32'(busLin.hold_kernel_o), mRel ? 32'(0) : 32'(1));
         checkOutput("wready relu", 32'(busRelu.window_ready_o), 32'(expReady));
         checkOutput("wready lin", 32'(busLin.window_ready_o), 32'(expReady));
         checkOutput("rvalid relu", 32'(busRelu.result_valid_o), 32'(mOut));
         checkOutput("rvalid lin", 32'(busLin.result_valid_o), 32'(mOut));
         if (mOut) begin
            checkOutput("result relu", busRelu.result_o, mExpRelu);
            checkOutput("result lin", busLin.result_o, mExpLin);
         end
         if (enable) begin
            if (mRel) begin
               mRel = 0;
            end else if (mOut) begin
               if (busRelu.result_ready_i) begin
                  mOut = 0;
                  mCount++;
                  if (mCount == NW) begin
                     mCount = 0;
                     mRel   = 1;
                  end
               end
            end else if (mBusy) begin
               mLeft--;
               if (mLeft == 0) begin
                  mBusy = 0;
                  mOut  = 1;
               end
            end else if (expReady) begin
               mBusy    = 1;
               mLeft    = TAPS + 1;
               mExpRelu = refPixel(1'b1);
               mExpLin  = refPixel(1'b0);
            end
         end
      end
   end

   // Enable toggles randomly only during the random phase.
   initial begin
      enable = 1'b1;
      forever begin
         @(posedge clock);
         #2;
         enable = randEn ? ($urandom_range(0, 5) != 0) : 1'b1;
      end
   end

   function automatic logic [31:0] randWord();
      int v;
      if ($urandom_range(0, 7) == 0) return $urandom;
      v = int'($urandom_range(0, 524288)) - 262144;
      return v;
   endfunction

   task automatic setUniform(input logic [31:0] k, input logic [31:0] w, input logic [31:0] b);
      for (int i = 0; i < TAPS; i++) begin
         busRelu.kernel_i[i] = k;
         busRelu.window_i[i] = w;
      end
      busRelu.bias_i = b;
   endtask

   task automatic setRandom();
      for (int i = 0; i < TAPS; i++) begin
         busRelu.kernel_i[i] = randWord();
         busRelu.window_i[i] = randWord();
      end
      busRelu.bias_i = randWord();
   endtask

   task automatic scrambleWindow();
      for (int i = 0; i < TAPS; i++) busRelu.window_i[i] = $urandom;
   endtask

   // Waits for the window to be taken; returns 0 on timeout.
   task automatic waitAccept(output bit seen);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clock);
         if (busRelu.window_ready_o) seen = 1;
      end
      if (!seen) reportTimeout("window accept");
   endtask

   // One full window transaction: optional kernel_valid gap, accept,
   // result wait, ready back-pressure, transfer, optional release check.
   task automatic applyStimulus(input int readyDelay, input int kvDropCycles, input bit checkLatency,
                                input bit checkLiteral, input logic [31:0] litRelu,
                                input logic [31:0] litLin, input bit expectRelease);
      bit seen;
      int cycles;
      @(posedge clock);
      #2;
      if (kvDropCycles > 0) begin
         busRelu.kernel_valid_i = '0;
         busRelu.window_valid_i = 1'b1;
         repeat (kvDropCycles) @(posedge clock);
         #2;
      end
      busRelu.kernel_valid_i = '1;
      busRelu.window_valid_i = 1'b1;
      waitAccept(seen);
      @(posedge clock);
      #2;
      busRelu.window_valid_i = 1'($urandom_range(0, 1));
      scrambleWindow();
      if (!seen) begin
         busRelu.window_valid_i = 1'b0;
         return;
      end
      seen   = 0;
      cycles = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clock);
         cycles++;
         if (busRelu.result_valid_o) seen = 1;
      end
      if (!seen) begin
         reportTimeout("result valid");
         busRelu.window_valid_i = 1'b0;
         return;
      end
      if (checkLatency) checkOutput("latency", 32'(cycles), 32'(TAPS + 2));
      if (checkLiteral) begin
         checkOutput("literal relu", busRelu.result_o, litRelu);
         checkOutput("literal lin", busLin.result_o, litLin);
      end
      repeat (readyDelay) @(negedge clock);
      if (checkLiteral && readyDelay > 0) checkOutput("stable after stall", busRelu.result_o, litRelu);
      @(posedge clock);
      #2;
      busRelu.result_ready_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock);
         if (enable) seen = 1;
      end
      if (!seen) reportTimeout("transfer");
      @(posedge clock);
      #2;
      busRelu.result_ready_i = 1'b0;
      busRelu.window_valid_i = 1'b0;
      if (expectRelease) begin
         checkOutput("release hold low", 32'(busRelu.hold_kernel_o), 32'(0));
         @(posedge clock);
         #2;
         checkOutput("release hold back", 32'(busRelu.hold_kernel_o), 32'(1));
      end
   endtask

   // Reset lands while the MAC is on tap 4.
   task automatic resetMidMac();
      bit seen;
      @(posedge clock);
      #2;
      setUniform(32'h0003_0000, 32'h0001_0000, 32'h0);
      busRelu.kernel_valid_i = '1;
      busRelu.window_valid_i = 1'b1;
      waitAccept(seen);
      @(posedge clock);
      #2;
      busRelu.window_valid_i = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset valid", 32'(busRelu.result_valid_o), 32'(0));
      checkOutput("midreset result", busRelu.result_o, 32'(0));
      checkOutput("midreset hold", 32'(busLin.hold_kernel_o), 32'(1));
      checkOutput("midreset wready", 32'(busLin.window_ready_o), 32'(0));
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      randEn       = 1'b0;
      reset_n      = 1'b0;
      busRelu.kernel_valid_i = '0;
      busRelu.window_valid_i = 1'b0;
      busRelu.result_ready_i = 1'b0;
      setUniform(32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clock);
      #2;
      checkOutput("initial result", busRelu.result_o, 32'(0));
      checkOutput("initial hold", 32'(busRelu.hold_kernel_o), 32'(1));
      reset_n = 1'b1;
      $display("[TB] directed transactions");
      setUniform(32'h0001_0000, 32'h0002_0000, 32'h0000_8000);
      applyStimulus(0, 0, 1, 1, 32'h0012_8000, 32'h0012_8000, 0);
      setUniform(32'hFFFF_0000, 32'h0002_0000, 32'h0000_8000);
      applyStimulus(0, 0, 1, 1, 32'h0000_0000, 32'hFFEE_8000, 0);
      setUniform(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
      applyStimulus(5, 0, 1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
      setRandom();
      applyStimulus(1, 4, 1, 0, 32'h0, 32'h0, 0);
      $display("[TB] reset during MAC");
      resetMidMac();
      setUniform(32'h0001_0000, 32'h0002_0000, 32'h0000_8000);
      applyStimulus(0, 0, 1, 1, 32'h0012_8000, 32'h0012_8000, 0);
      $display("[TB] random transactions");
      randEn = 1'b1;
      for (int n = 0; n < 40; n++) begin
         setRandom();
         applyStimulus($urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       0, 0, 32'h0, 32'h0, 0);
      end
      randEn = 1'b0;
      repeat (5) @(posedge clock);
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
